// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and helpers for the data-memory responder
package dmem_pkg;

    localparam int DMEM_DW = 32;
    localparam int WAIT_W  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Number of word-index bits needed to address a power-of-two array of depth words.
    function automatic int addr_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 17; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous single-port word RAM with registered read, no reset
import dmem_pkg::*;

module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [DMEM_DW-1:0] din_i,
    output logic [DMEM_DW-1:0] dout_o
);

    logic [DMEM_DW-1:0] mem_q [DEPTH_WORDS];
    logic [DMEM_DW-1:0] dout_q;

    // Read-first port: the registered read returns the word as it was before a same-edge write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
        dout_q <= mem_q[addr_i];
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with optional wait states (DMEM_WAIT_EN)
import dmem_pkg::*;

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               dm_en_i,
    input  logic               dm_wen_i,
    input  logic [31:0]        dm_addr_i,
    input  logic [DMEM_DW-1:0] dm_din_i,
    output logic [DMEM_DW-1:0] dm_dout_o,
    output logic               dm_busy_o,
    output logic               dm_oor_o
);

    localparam int AW = addr_w(DEPTH_WORDS);

    // The access that completes at the coming edge (if cmp_valid), whichever path it came from.
    logic               cmp_valid;
    logic               cmp_wen;
    logic [31:0]        cmp_addr;
    logic [DMEM_DW-1:0] cmp_din;
    logic               cmp_in_range;

`ifdef DMEM_WAIT_EN
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]        cap_addr_q, cap_addr_d;
    logic [DMEM_DW-1:0] cap_din_q, cap_din_d;
    logic               cap_wen_q, cap_wen_d;

    // Accept in IDLE, count down in WAIT, and pick which request completes this cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cap_addr_d = cap_addr_q;
        cap_din_d  = cap_din_q;
        cap_wen_d  = cap_wen_q;
        cmp_valid  = 1'b0;
        cmp_wen    = dm_wen_i;
        cmp_addr   = dm_addr_i;
        cmp_din    = dm_din_i;
        case (state_q)
            IDLE: begin
                if (dm_en_i) begin
                    if (WAIT_CYCLES == 0) begin
                        cmp_valid = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                        cap_addr_d = dm_addr_i;
                        cap_din_d  = dm_din_i;
                        cap_wen_d  = dm_wen_i;
                    end
                end
            end
            WAIT: begin
                cmp_wen  = cap_wen_q;
                cmp_addr = cap_addr_q;
                cmp_din  = cap_din_q;
                if (wait_cnt_q == '0) begin
                    cmp_valid = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counter and request capture; reset abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            cap_addr_q <= '0;
            cap_din_q  <= '0;
            cap_wen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cap_addr_q <= cap_addr_d;
            cap_din_q  <= cap_din_d;
            cap_wen_q  <= cap_wen_d;
        end
    end

    assign dm_busy_o = (state_q == WAIT);
`else
    // Single-cycle responder: every request completes at its acceptance edge.
    always_comb begin
        cmp_valid = dm_en_i;
        cmp_wen   = dm_wen_i;
        cmp_addr  = dm_addr_i;
        cmp_din   = dm_din_i;
    end

    assign dm_busy_o = 1'b0;
`endif

    logic unused_cfg;
    logic unused_addr_bits;
    assign unused_cfg       = (WAIT_CYCLES != 0);
    assign unused_addr_bits = ^cmp_addr[1:0];

    assign cmp_in_range = ((cmp_addr >> (AW + 2)) == 32'd0);

    logic               ram_we;
    logic [DMEM_DW-1:0] ram_dout;

    // Only in-range writes reach the array, and never on a reset edge.
    assign ram_we = cmp_valid & cmp_wen & cmp_in_range & ~rst_i;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (ram_we),
        .addr_i (cmp_addr[AW+1:2]),
        .din_i  (cmp_din),
        .dout_o (ram_dout)
    );

    logic [DMEM_DW-1:0] dout_q;
    logic               sel_ram_q;
    logic               oor_q;

    // Read data lives in the RAM output register for the cycle after a read completes,
    // then is copied into dout_q so later RAM activity cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q    <= '0;
            sel_ram_q <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            oor_q <= cmp_valid & ~cmp_in_range;
            if (sel_ram_q) begin
                dout_q <= ram_dout;
            end
            if (cmp_valid && !cmp_wen) begin
                if (cmp_in_range) begin
                    sel_ram_q <= 1'b1;
                end else begin
                    sel_ram_q <= 1'b0;
                    dout_q    <= '0;
                end
            end else begin
                sel_ram_q <= 1'b0;
            end
        end
    end

    assign dm_dout_o = sel_ram_q ? ram_dout : dout_q;
    assign dm_oor_o  = oor_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

`ifdef DMEM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dm_en_i = 1'b0;
    logic        dm_wen_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_din_i = '0;
    logic [31:0] dm_dout_o;
    logic        dm_busy_o;
    logic        dm_oor_o;

    int total = 0;
    int bad   = 0;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .dm_en_i   (dm_en_i),
        .dm_wen_i  (dm_wen_i),
        .dm_addr_i (dm_addr_i),
        .dm_din_i  (dm_din_i),
        .dm_dout_o (dm_dout_o),
        .dm_busy_o (dm_busy_o),
        .dm_oor_o  (dm_oor_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // One request; optionally drives a conflicting write during the busy cycles.
    task automatic access(input string tag, input logic wen, input logic [31:0] addr,
                          input logic [31:0] din, input logic exp_oor,
                          input logic [31:0] exp_dout, input logic noise,
                          input logic [31:0] noise_addr);
        int busy_n;
        int oor_n;
        busy_n = 0;
        oor_n  = 0;
        @(negedge clk_i);
        dm_en_i   = 1'b1;
        dm_wen_i  = wen;
        dm_addr_i = addr;
        dm_din_i  = din;
        @(posedge clk_i);
        #1;
        dm_en_i = noise;
        if (noise) begin
            dm_wen_i  = 1'b1;
            dm_addr_i = noise_addr;
            dm_din_i  = 32'hBAD0BAD0;
        end
        for (int i = 0; i <= W; i++) begin
            if (i == W) dm_en_i = 1'b0;
            @(negedge clk_i);
            if (dm_busy_o) busy_n++;
            if (dm_oor_o) oor_n++;
            if (i < W) begin
                @(posedge clk_i);
                #1;
            end
        end
        check({tag, "_busy_cycles"}, busy_n, W);
        check({tag, "_busy_done"}, {31'd0, dm_busy_o}, 32'd0);
        check({tag, "_oor"}, {31'd0, dm_oor_o}, {31'd0, exp_oor});
        check({tag, "_dout"}, dm_dout_o, exp_dout);
        @(negedge clk_i);
        if (dm_oor_o) oor_n++;
        check({tag, "_oor_pulses"}, oor_n, {31'd0, exp_oor});
    endtask

    initial begin
        logic [31:0] b2b_exp [3];
        b2b_exp[0] = 32'h11111111;
        b2b_exp[1] = 32'h44444444;
        b2b_exp[2] = 32'h88888888;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", {31'd0, dm_busy_o}, 32'd0);
        check("rst_dout", dm_dout_o, 32'd0);
        check("rst_oor", {31'd0, dm_oor_o}, 32'd0);
        #1 rst_i = 1'b0;

        access("wr_w0",   1'b1, 32'h0000_0000, 32'h11111111, 1'b0, 32'h0, 1'b0, 32'h0);
        access("wr_10",   1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0);
        access("wr_24",   1'b1, 32'h0000_0024, 32'h24242424, 1'b0, 32'h0, 1'b0, 32'h0);
        access("rd_10",   1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
        access("rd_13",   1'b0, 32'h0000_0013, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
        access("wr_oor",  1'b1, 32'h0000_1000, 32'h00000055, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        access("rd_oor",  1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        access("rd_w0",   1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h11111111, 1'b0, 32'h0);
        access("rd_noise",1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0000_0024);
        access("rd_24",   1'b0, 32'h0000_0024, 32'h0, 1'b0, 32'h24242424, 1'b0, 32'h0);
        access("wr_20",   1'b1, 32'h0000_0020, 32'hAAAAAAAA, 1'b0, 32'h24242424, 1'b0, 32'h0);

        // Abort a write of 0x12345678 to 0x20 with reset.
        @(negedge clk_i);
        dm_en_i   = 1'b1;
        dm_wen_i  = 1'b1;
        dm_addr_i = 32'h0000_0020;
        dm_din_i  = 32'h12345678;
`ifdef DMEM_WAIT_EN
        @(posedge clk_i);
        #1;
        dm_en_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
`else
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        dm_en_i = 1'b0;
`endif
        @(negedge clk_i);
        check("abort_busy", {31'd0, dm_busy_o}, 32'd0);
        check("abort_dout", dm_dout_o, 32'd0);
        check("abort_oor", {31'd0, dm_oor_o}, 32'd0);
        access("rd_20",   1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h0);

        access("wr_4",    1'b1, 32'h0000_0004, 32'h44444444, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h0);
        access("wr_8",    1'b1, 32'h0000_0008, 32'h88888888, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h0);

`ifdef DMEM_WAIT_EN
        access("seq_0",   1'b0, 32'h0000_0000, 32'h0, 1'b0, b2b_exp[0], 1'b0, 32'h0);
        access("seq_4",   1'b0, 32'h0000_0004, 32'h0, 1'b0, b2b_exp[1], 1'b0, 32'h0);
        access("seq_8",   1'b0, 32'h0000_0008, 32'h0, 1'b0, b2b_exp[2], 1'b0, 32'h0);
`else
        @(negedge clk_i);
        dm_en_i   = 1'b1;
        dm_wen_i  = 1'b0;
        dm_addr_i = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            if (k == 2) dm_en_i = 1'b0;
            else dm_addr_i = 32'(4 * (k + 1));
            @(negedge clk_i);
            check($sformatf("b2b_dout%0d", k), dm_dout_o, b2b_exp[k]);
            check($sformatf("b2b_busy%0d", k), {31'd0, dm_busy_o}, 32'd0);
        end
`endif

        repeat (2) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
